// File: rtl/ssm_word_dispatch.sv
// ssm_word_dispatch: lookahead FIFO handing consecutive bitstream words to substream parsers in index order
//   clk, rst (async, active-high)    flush: sync clear of FIFO and statistics
//   in_vld/in_data/in_rdy            word input, push when in_vld & in_rdy
//   ssm_req/ssm_gnt/ssm_data         per-substream request, same-cycle grant and word
//   level, words_served, stall_cnt, underflow_seen: occupancy and statistics
module ssm_word_dispatch #(
  parameter int NUM_SSM = 4,
  parameter int DW      = 128,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_vld,
  input  logic [DW-1:0]             in_data,
  output logic                      in_rdy,
  input  logic [NUM_SSM-1:0]        ssm_req,
  output logic [NUM_SSM-1:0]        ssm_gnt,
  output logic [NUM_SSM*DW-1:0]     ssm_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [31:0]               words_served,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic                      underflow_seen
);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = $clog2(NUM_SSM + 1);
  logic [DW-1:0]    mem [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [31:0]      ws_q, ws_d;
  logic [CNT_W-1:0] st_q, st_d;
  logic             uf_q, uf_d;
  logic [RW-1:0]    acc, pop;
  logic             push, stall;
  assign in_rdy = ~rst & (level_q < LW'(DEPTH));
  assign push   = in_vld & in_rdy & ~flush;
  // rank(i) = requesters below i; lane i takes the rank(i)-th word after rd_ptr
  always_comb begin
    acc      = '0;
    pop      = '0;
    ssm_gnt  = '0;
    ssm_data = '0;
    for (int i = 0; i < NUM_SSM; i++) begin
      ssm_gnt[i] = ~rst & ~flush & ssm_req[i] & (int'(acc) < int'(level_q));
      ssm_data[i*DW +: DW] = mem[PW'((int'(rd_q) + int'(acc)) % DEPTH)];
      pop = pop + RW'(ssm_gnt[i]);
      acc = acc + RW'(ssm_req[i]);
    end
  end
  assign stall = |(ssm_req & ~ssm_gnt);
  always_comb begin
    rd_d    = flush ? '0 : PW'((int'(rd_q) + int'(pop)) % DEPTH);
    wr_d    = flush ? '0 : push ? PW'((int'(wr_q) + 1) % DEPTH) : wr_q;
    level_d = flush ? '0 : level_q + LW'(push) - LW'(pop);
    ws_d    = flush ? '0 : ws_q + 32'(pop);
    st_d    = flush ? '0 : (stall && !(&st_q)) ? st_q + 1'b1 : st_q;
    uf_d    = flush ? 1'b0 : uf_q | (stall & (level_q == '0));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
      ws_q    <= '0;
      st_q    <= '0;
      uf_q    <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      level_q <= level_d;
      ws_q    <= ws_d;
      st_q    <= st_d;
      uf_q    <= uf_d;
    end
  // storage needs no reset: a slot is only read once level says it was written
  always_ff @(posedge clk)
    if (push) mem[wr_q] <= in_data;
  assign level          = level_q;
  assign words_served   = ws_q;
  assign stall_cnt      = st_q;
  assign underflow_seen = uf_q;
endmodule

// File: tb/tb_ssm_word_dispatch.sv
// tb_ssm_word_dispatch: directed vector table plus reset and stall-saturation sequences
module tb_ssm_word_dispatch;
  localparam int N = 4, DW = 128, DEPTH = 8, CNT_W = 3;
  logic clk = 0, rst = 1, flush = 0, in_vld = 0;
  logic [DW-1:0] in_data = '0;
  logic [N-1:0] ssm_req = '0;
  logic in_rdy, underflow_seen;
  logic [N-1:0] ssm_gnt;
  logic [N*DW-1:0] ssm_data;
  logic [3:0] level;
  logic [31:0] words_served;
  logic [CNT_W-1:0] stall_cnt;
  int tests = 0, fails = 0;
  ssm_word_dispatch #(.NUM_SSM(N), .DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_vld(in_vld), .in_data(in_data),
    .in_rdy(in_rdy), .ssm_req(ssm_req), .ssm_gnt(ssm_gnt), .ssm_data(ssm_data),
    .level(level), .words_served(words_served), .stall_cnt(stall_cnt),
    .underflow_seen(underflow_seen));
  always #5 clk = ~clk;
  typedef struct {
    logic fl, vld;
    logic [7:0] din;
    logic [3:0] req;
    logic rdy;
    logic [3:0] gnt;
    logic [3:0][7:0] sd;
    int lvl, ws, st;
    logic uf;
  } vec_t;
  vec_t v[$];
  function automatic vec_t mk(logic fl, logic vld, int din, logic [3:0] req, logic rdy,
                              logic [3:0] gnt, logic [31:0] sd, int lvl, int ws, int st, logic uf);
    vec_t r;
    r.fl = fl; r.vld = vld; r.din = 8'(din); r.req = req; r.rdy = rdy; r.gnt = gnt;
    r.sd = sd; r.lvl = lvl; r.ws = ws; r.st = st; r.uf = uf;
    return r;
  endfunction
  function automatic logic [DW-1:0] pat(logic [7:0] id);
    return {16{id}};
  endfunction
  task automatic chk(string name, int idx, logic [DW-1:0] act, logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask
  initial begin
    for (int k = 0; k < 8; k++) v.push_back(mk(0, 1, k, 0, 1, 0, 0, k, 0, 0, 0));
    v.push_back(mk(0, 1, 8, 4'h0, 0, 4'h0, 32'h0, 8, 0, 0, 0));
    v.push_back(mk(0, 1, 8, 4'hf, 0, 4'hf, 32'h03020100, 8, 0, 0, 0));
    v.push_back(mk(0, 1, 8, 4'h0, 1, 4'h0, 32'h0, 4, 4, 0, 0));
    v.push_back(mk(0, 0, 0, 4'h3, 1, 4'h3, 32'h00000504, 5, 4, 0, 0));
    v.push_back(mk(0, 1, 9, 4'h5, 1, 4'h5, 32'h00070006, 3, 6, 0, 0));
    v.push_back(mk(0, 0, 0, 4'hb, 1, 4'h3, 32'h00000908, 2, 8, 0, 0));
    v.push_back(mk(0, 0, 0, 4'h8, 1, 4'h0, 32'h0, 0, 10, 1, 0));
    v.push_back(mk(0, 1, 10, 4'h8, 1, 4'h0, 32'h0, 0, 10, 2, 1));
    v.push_back(mk(0, 0, 0, 4'h8, 1, 4'h8, 32'h0a000000, 1, 10, 3, 1));
    for (int k = 0; k < 7; k++) v.push_back(mk(0, 1, 11 + k, 0, 1, 0, 0, k, 11, 3, 1));
    v.push_back(mk(0, 0, 0, 4'h7, 1, 4'h7, 32'h000d0c0b, 7, 11, 3, 1));
    v.push_back(mk(0, 0, 0, 4'hf, 1, 4'hf, 32'h11100f0e, 4, 14, 3, 1));
    for (int k = 0; k < 5; k++) v.push_back(mk(0, 1, 18 + k, 0, 1, 0, 0, k, 18, 3, 1));
    v.push_back(mk(1, 1, 23, 4'hf, 1, 4'h0, 32'h0, 5, 18, 3, 1));
    v.push_back(mk(0, 0, 0, 4'h0, 1, 4'h0, 32'h0, 0, 0, 0, 0));
    v.push_back(mk(0, 0, 0, 4'h1, 1, 4'h0, 32'h0, 0, 0, 0, 0));
    v.push_back(mk(0, 1, 24, 4'h0, 1, 4'h0, 32'h0, 0, 0, 1, 1));
    v.push_back(mk(0, 0, 0, 4'h1, 1, 4'h1, 32'h00000018, 1, 0, 1, 1));
    in_vld = 1; ssm_req = 4'hf; in_data = pat(8'h55);
    #1;
    chk("rst_in_rdy", -1, DW'(in_rdy), DW'(0));
    chk("rst_gnt", -1, DW'(ssm_gnt), DW'(0));
    chk("rst_level", -1, DW'(level), DW'(0));
    chk("rst_ws", -1, DW'(words_served), DW'(0));
    @(negedge clk);
    rst = 0; in_vld = 0; ssm_req = '0;
    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk);
      flush = v[i].fl; in_vld = v[i].vld; in_data = pat(v[i].din); ssm_req = v[i].req;
      #1;
      chk("in_rdy", i, DW'(in_rdy), DW'(v[i].rdy));
      chk("gnt", i, DW'(ssm_gnt), DW'(v[i].gnt));
      chk("level", i, DW'(level), DW'(v[i].lvl));
      chk("words_served", i, DW'(words_served), DW'(v[i].ws));
      chk("stall_cnt", i, DW'(stall_cnt), DW'(v[i].st));
      chk("underflow", i, DW'(underflow_seen), DW'(v[i].uf));
      for (int j = 0; j < N; j++)
        if (v[i].gnt[j]) chk($sformatf("data%0d", j), i, ssm_data[j*DW +: DW], pat(v[i].sd[j]));
    end
    @(negedge clk);
    flush = 0; in_vld = 0; ssm_req = 4'h1;
    repeat (10) @(negedge clk);
    #1;
    chk("stall_sat", 99, DW'(stall_cnt), DW'(7));
    chk("sat_gnt", 99, DW'(ssm_gnt), DW'(0));
    chk("sat_level", 99, DW'(level), DW'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
